mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between instruction fetch (read-only) and the data-memory stage (load/store).
- Arbitrates between the two requesters, tracks the in-flight read through a fixed-latency memory, and routes read data back to the requester that issued it.
- Data accesses have priority. A streak counter prevents fetch starvation.
- The pipeline stalls any requester whose gnt is low.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_rd_tracker.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the memory port arbiter
package mem_arb_pkg;

  // Wide enough for LATENCY up to 7 and MAX_STREAK up to 15.
  localparam int CNT_W    = 3;
  localparam int STREAK_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_rd_tracker.sv
// rtl/mem_rd_tracker.sv - tracks the one in-flight read and routes its rvalid to the owner
module mem_rd_tracker
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   rd_start_i,
  input  owner_e rd_owner_i,
  output logic   busy_o,
  output logic   last_o,
  output logic   if_rvalid_o,
  output logic   d_rvalid_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  owner_e           owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_IF;
    end else if (rd_start_i) begin
      state_q <= ST_WAIT;
      cnt_q   <= CNT_W'(LATENCY);
      owner_q <= rd_owner_i;
    end else if (state_q == ST_WAIT) begin
      if (cnt_q == CNT_W'(1)) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // The cycle with cnt==1 is both the data-return cycle and the next issue slot.
  assign last_o      = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
  assign busy_o      = (state_q == ST_WAIT);
  assign if_rvalid_o = last_o && (owner_q == OWN_IF);
  assign d_rvalid_o  = last_o && (owner_q == OWN_D);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and data access
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                can_issue, if_sel, d_sel, rd_start, last;
  owner_e              rd_owner;

  mem_rd_tracker #(
    .LATENCY(LATENCY)
  ) u_trk (
    .clk        (clk),
    .reset      (reset),
    .rd_start_i (rd_start),
    .rd_owner_i (rd_owner),
    .busy_o     (busy),
    .last_o     (last),
    .if_rvalid_o(if_rvalid),
    .d_rvalid_o (d_rvalid)
  );

  assign can_issue = !busy || last;

  always_comb begin
    if_sel = 1'b0;
    d_sel  = 1'b0;
    if (can_issue) begin
      if (if_req && d_req) begin
        if (streak_q == STREAK_MAX) if_sel = 1'b1;
        else                        d_sel  = 1'b1;
      end else begin
        if_sel = if_req;
        d_sel  = d_req;
      end
    end
  end

  // Streak only grows while fetch is actually waiting behind data traffic.
  always_comb begin
    streak_d = streak_q;
    if (d_sel) begin
      if (!if_req)                   streak_d = '0;
      else if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
    end else if (if_sel) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  assign if_gnt   = if_sel;
  assign d_gnt    = d_sel;
  assign rd_start = if_sel || (d_sel && !d_we);
  assign rd_owner = if_sel ? OWN_IF : OWN_D;

  assign m_en    = if_sel || d_sel;
  assign m_we    = d_sel && d_we;
  assign m_addr  = d_sel ? d_addr : if_addr;
  assign m_wdata = d_sel ? d_wdata : '0;
  assign m_be    = d_sel ? d_be : {BE_W{1'b1}};

  assign if_rdata = if_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;

  logic        u2_if_gnt, u2_if_rvalid, u2_d_gnt, u2_d_rvalid, u2_m_en, u2_m_we, u2_busy;
  logic [31:0] u2_if_rdata, u2_d_rdata, u2_m_addr, u2_m_wdata, u2_m_rdata;
  logic [3:0]  u2_m_be;
  logic        u3_if_gnt, u3_if_rvalid, u3_d_gnt, u3_d_rvalid, u3_m_en, u3_m_we, u3_busy;
  logic [31:0] u3_if_rdata, u3_d_rdata, u3_m_addr, u3_m_wdata, u3_m_rdata;
  logic [3:0]  u3_m_be;

  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .MAX_STREAK(4)) u2 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(u2_if_gnt), .if_rvalid(u2_if_rvalid), .if_rdata(u2_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(u2_d_gnt), .d_rvalid(u2_d_rvalid), .d_rdata(u2_d_rdata),
    .m_en(u2_m_en), .m_we(u2_m_we), .m_addr(u2_m_addr), .m_wdata(u2_m_wdata), .m_be(u2_m_be),
    .m_rdata(u2_m_rdata), .busy(u2_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .MAX_STREAK(4)) u3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(u3_if_gnt), .if_rvalid(u3_if_rvalid), .if_rdata(u3_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(u3_d_gnt), .d_rvalid(u3_d_rvalid), .d_rdata(u3_d_rdata),
    .m_en(u3_m_en), .m_we(u3_m_we), .m_addr(u3_m_addr), .m_wdata(u3_m_wdata), .m_be(u3_m_be),
    .m_rdata(u3_m_rdata), .busy(u3_busy)
  );

  // Memory models: word-indexed, read data appears LATENCY cycles after the read edge.
  logic [31:0] mem2 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p2 [0:1];
  logic [31:0] p3 [0:2];
  assign u2_m_rdata = p2[1];
  assign u3_m_rdata = p3[2];

  always @(posedge clk) begin
    if (pl_en) mem2[pl_idx] <= pl_data;
    else if (u2_m_en && u2_m_we)
      for (int b = 0; b < 4; b++)
        if (u2_m_be[b]) mem2[u2_m_addr[9:2]][8*b +: 8] <= u2_m_wdata[8*b +: 8];
    p2[0] <= (u2_m_en && !u2_m_we) ? mem2[u2_m_addr[9:2]] : 32'h0;
    p2[1] <= p2[0];
  end

  always @(posedge clk) begin
    if (pl_en) mem3[pl_idx] <= pl_data;
    else if (u3_m_en && u3_m_we)
      for (int b = 0; b < 4; b++)
        if (u3_m_be[b]) mem3[u3_m_addr[9:2]][8*b +: 8] <= u3_m_wdata[8*b +: 8];
    p3[0] <= (u3_m_en && !u3_m_we) ? mem3[u3_m_addr[9:2]] : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = addr[9:2]; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (u2_if_gnt !== 1'b0) begin n_err++; $display("FAIL rst_if_gnt got=%b want=0", u2_if_gnt); end
    n_cmp++; if (u2_d_gnt !== 1'b0) begin n_err++; $display("FAIL rst_d_gnt got=%b want=0", u2_d_gnt); end
    n_cmp++; if ({u2_if_rvalid, u2_d_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid got=%b want=00", {u2_if_rvalid, u2_d_rvalid}); end
    n_cmp++; if ({u2_m_en, u2_m_we} !== 2'b00) begin n_err++; $display("FAIL rst_m_en_we got=%b want=00", {u2_m_en, u2_m_we}); end
    n_cmp++; if ({u2_busy, u3_busy} !== 2'b00) begin n_err++; $display("FAIL rst_busy got=%b want=00", {u2_busy, u3_busy}); end
    n_cmp++; if ({u3_if_rvalid, u3_d_rvalid, u3_m_en} !== 3'b000) begin n_err++; $display("FAIL rst_u3_outs got=%b want=000", {u3_if_rvalid, u3_d_rvalid, u3_m_en}); end
  endtask

  task automatic test_single_fetch();
    preload(32'h100, 32'hDEADBEEF);
    do_reset();
    if_req = 1'b1; if_addr = 32'h100; #1;
    n_cmp++; if (u2_if_gnt !== 1'b1) begin n_err++; $display("FAIL fetch_gnt got=%b want=1", u2_if_gnt); end
    n_cmp++; if ({u2_m_en, u2_m_we, u2_m_be} !== 6'b10_1111) begin n_err++; $display("FAIL fetch_m_ctl got=%b want=101111", {u2_m_en, u2_m_we, u2_m_be}); end
    n_cmp++; if (u2_m_addr !== 32'h100) begin n_err++; $display("FAIL fetch_m_addr got=%h want=00000100", u2_m_addr); end
    @(negedge clk); if_req = 1'b0; #1;
    n_cmp++; if ({u2_busy, u2_if_rvalid, u2_if_gnt} !== 3'b100) begin n_err++; $display("FAIL fetch_t1 busy/rv/gnt got=%b want=100", {u2_busy, u2_if_rvalid, u2_if_gnt}); end
    @(negedge clk); #1;
    n_cmp++; if (u2_if_rvalid !== 1'b1) begin n_err++; $display("FAIL fetch_rvalid got=%b want=1", u2_if_rvalid); end
    n_cmp++; if (u2_if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL fetch_rdata got=%h want=deadbeef", u2_if_rdata); end
    n_cmp++; if (u2_d_rvalid !== 1'b0) begin n_err++; $display("FAIL fetch_d_rvalid got=%b want=0", u2_d_rvalid); end
    @(negedge clk); #1;
    n_cmp++; if ({u2_busy, u2_if_rvalid} !== 2'b00) begin n_err++; $display("FAIL fetch_t3 busy/rv got=%b want=00", {u2_busy, u2_if_rvalid}); end
    n_cmp++; if (u2_if_rdata !== 32'h0) begin n_err++; $display("FAIL fetch_rdata_idle got=%h want=0", u2_if_rdata); end
  endtask

  task automatic test_store_load();
    preload(32'h40, 32'h0);
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'hF; #1;
    n_cmp++; if (u2_d_gnt !== 1'b1) begin n_err++; $display("FAIL store_gnt got=%b want=1", u2_d_gnt); end
    n_cmp++; if ({u2_m_en, u2_m_we, u2_m_be} !== 6'b11_1111) begin n_err++; $display("FAIL store_m_ctl got=%b want=111111", {u2_m_en, u2_m_we, u2_m_be}); end
    n_cmp++; if (u2_m_wdata !== 32'h12345678) begin n_err++; $display("FAIL store_m_wdata got=%h want=12345678", u2_m_wdata); end
    @(negedge clk); d_we = 1'b0; #1;
    n_cmp++; if ({u2_d_gnt, u2_m_we, u2_busy} !== 3'b100) begin n_err++; $display("FAIL load_gnt gnt/we/busy got=%b want=100", {u2_d_gnt, u2_m_we, u2_busy}); end
    n_cmp++; if (u2_d_rvalid !== 1'b0) begin n_err++; $display("FAIL store_no_rvalid got=%b want=0", u2_d_rvalid); end
    @(negedge clk); d_req = 1'b0; #1;
    n_cmp++; if ({u2_busy, u2_d_rvalid} !== 2'b10) begin n_err++; $display("FAIL load_t2 busy/rv got=%b want=10", {u2_busy, u2_d_rvalid}); end
    @(negedge clk); #1;
    n_cmp++; if ({u2_d_rvalid, u2_if_rvalid} !== 2'b10) begin n_err++; $display("FAIL load_rvalid d/if got=%b want=10", {u2_d_rvalid, u2_if_rvalid}); end
    n_cmp++; if (u2_d_rdata !== 32'h12345678) begin n_err++; $display("FAIL load_rdata got=%h want=12345678", u2_d_rdata); end
    // Partial-byte store passes its byte enables through.
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hAAAA5555; #1;
    n_cmp++; if ({u2_d_gnt, u2_m_be} !== 5'b1_0011) begin n_err++; $display("FAIL store_be got=%b want=10011", {u2_d_gnt, u2_m_be}); end
    @(negedge clk); d_we = 1'b0; d_be = 4'hF; #1;
    @(negedge clk); d_req = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (u2_d_rdata !== 32'h12345555) begin n_err++; $display("FAIL store_be_rdata got=%h want=12345555", u2_d_rdata); end
  endtask

  task automatic test_anti_starvation();
    logic [9:0] exp_if;
    logic [9:0] got_if;
    int ng;
    exp_if = 10'b10000_10000;
    got_if = '0;
    ng = 0;
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1; d_be = 4'hF;
    for (int cyc = 0; cyc < 40 && ng < 10; cyc++) begin
      #1;
      if (u2_if_gnt && u2_d_gnt) begin n_cmp++; n_err++; $display("FAIL starve_both_gnt cycle=%0d got=11 want=one-hot", cyc); end
      if (u2_if_gnt || u2_d_gnt) begin got_if[ng] = u2_if_gnt; ng++; end
      @(negedge clk);
    end
    n_cmp++; if (ng !== 10) begin n_err++; $display("FAIL starve_grant_count got=%0d want=10", ng); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (got_if[i] !== exp_if[i]) begin n_err++; $display("FAIL starve_order grant=%0d got_if=%b want_if=%b", i, got_if[i], exp_if[i]); end
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    preload(32'h200, 32'hCAFE0200);
    do_reset();
    if_req = 1'b1; if_addr = 32'h200;
    for (int t = 0; t < 10; t++) begin
      #1;
      n_cmp++; if (u3_if_gnt !== (t % 3 == 0)) begin n_err++; $display("FAIL b2b_gnt T%0d got=%b want=%b", t, u3_if_gnt, (t % 3 == 0)); end
      n_cmp++; if (u3_if_rvalid !== (t >= 3 && t % 3 == 0)) begin n_err++; $display("FAIL b2b_rvalid T%0d got=%b want=%b", t, u3_if_rvalid, (t >= 3 && t % 3 == 0)); end
      n_cmp++; if (u3_busy !== (t >= 1)) begin n_err++; $display("FAIL b2b_busy T%0d got=%b want=%b", t, u3_busy, (t >= 1)); end
      if (t == 6) begin
        n_cmp++; if (u3_if_rdata !== 32'hCAFE0200) begin n_err++; $display("FAIL b2b_rdata got=%h want=cafe0200", u3_if_rdata); end
      end
      @(negedge clk);
    end
    if_req = 1'b0;
  endtask

  task automatic test_collision();
    preload(32'h40, 32'hA5A50001);
    preload(32'h100, 32'hDEADBEEF);
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF; #1;
    n_cmp++; if (u2_d_gnt !== 1'b1) begin n_err++; $display("FAIL coll_load_gnt got=%b want=1", u2_d_gnt); end
    @(negedge clk); d_req = 1'b0; if_req = 1'b1; if_addr = 32'h100; #1;
    n_cmp++; if ({u2_if_gnt, u2_d_gnt} !== 2'b00) begin n_err++; $display("FAIL coll_wait_gnt got=%b want=00", {u2_if_gnt, u2_d_gnt}); end
    @(negedge clk); #1;
    n_cmp++; if ({u2_if_gnt, u2_d_rvalid, u2_if_rvalid} !== 3'b110) begin n_err++; $display("FAIL coll_b2b gnt/drv/ifrv got=%b want=110", {u2_if_gnt, u2_d_rvalid, u2_if_rvalid}); end
    n_cmp++; if (u2_d_rdata !== 32'hA5A50001) begin n_err++; $display("FAIL coll_d_rdata got=%h want=a5a50001", u2_d_rdata); end
    @(negedge clk); if_req = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if ({u2_if_rvalid, u2_d_rvalid} !== 2'b10) begin n_err++; $display("FAIL coll_if_rvalid if/d got=%b want=10", {u2_if_rvalid, u2_d_rvalid}); end
    n_cmp++; if (u2_if_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL coll_if_rdata got=%h want=deadbeef", u2_if_rdata); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    if_req = 1'b1; if_addr = 32'h200; #1;
    n_cmp++; if (u3_if_gnt !== 1'b1) begin n_err++; $display("FAIL rmr_gnt got=%b want=1", u3_if_gnt); end
    @(negedge clk); if_req = 1'b0; reset = 1'b1; #1;
    n_cmp++; if (u3_busy !== 1'b1) begin n_err++; $display("FAIL rmr_busy_t1 got=%b want=1", u3_busy); end
    @(negedge clk); reset = 1'b0; if_req = 1'b1; #1;
    n_cmp++; if ({u3_busy, u3_if_gnt} !== 2'b01) begin n_err++; $display("FAIL rmr_t2 busy/gnt got=%b want=01", {u3_busy, u3_if_gnt}); end
    @(negedge clk); if_req = 1'b0; #1;
    n_cmp++; if (u3_if_rvalid !== 1'b0) begin n_err++; $display("FAIL rmr_no_rvalid got=%b want=0", u3_if_rvalid); end
    // Streak cleared by reset: with both pending, data must win first.
    do_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; #1;
    n_cmp++; if ({u2_d_gnt, u2_if_gnt} !== 2'b10) begin n_err++; $display("FAIL rmr_streak_zero d/if got=%b want=10", {u2_d_gnt, u2_if_gnt}); end
    @(negedge clk); if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_store_load();
    test_anti_starvation();
    test_back_to_back();
    test_collision();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
